// File: rtl/pingpong_tile_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_tile_buffer
// Brief    : Two-bank ping-pong ROWS x LANES tile buffer streaming row vectors
//            to a systolic array; define SKEW_EN for diagonal wavefront output.
// Revision : 1.0 - initial release
// ============================================================================
module pingpong_tile_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int ROWS       = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           flush_i,
    input  logic                                           wr_en_i,
    input  logic [$clog2(ROWS)-1:0]                        wr_row_i,
    input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0]   wr_lane_i,
    input  logic [DATA_WIDTH-1:0]                          wr_data_i,
    input  logic                                           wr_commit_i,
    output logic                                           wr_ready_o,
    output logic                                           out_valid_o,
    input  logic                                           out_ready_i,
    output logic [DATA_WIDTH*LANES-1:0]                    out_data_o,
    output logic                                           out_last_o
);

    localparam int C_RW = $clog2(ROWS);
    localparam int C_LW = (LANES > 1) ? $clog2(LANES) : 1;
`ifdef SKEW_EN
    localparam int C_NBEATS = ROWS + LANES - 1;
`else
    localparam int C_NBEATS = ROWS;
`endif
    localparam int C_BW = $clog2(C_NBEATS + 1);

    localparam logic [0:0] C_IDLE   = 1'b0;
    localparam logic [0:0] C_STREAM = 1'b1;

    logic [DATA_WIDTH-1:0] mem_q [2][ROWS][LANES];
    logic [1:0]            full_q, full_d;
    logic                  wsel_q, wsel_d;
    logic                  rsel_q, rsel_d;
    logic [0:0]            state_q, state_d;
    logic [C_BW-1:0]       beat_q, beat_d;

    logic w_in_range;
    logic w_wr_ok;
    logic w_commit_ok;
    logic w_last;
    logic w_accept;

    // A writable bank is never full, so commit and release never collide.
    assign wr_ready_o  = ~full_q[wsel_q];
    assign w_in_range  = ({1'b0, wr_row_i}  < (C_RW + 1)'(ROWS)) &&
                         ({1'b0, wr_lane_i} < (C_LW + 1)'(LANES));
    assign w_wr_ok     = wr_en_i & wr_ready_o & w_in_range & ~flush_i;
    assign w_commit_ok = wr_commit_i & wr_ready_o & ~flush_i;
    assign w_last      = (beat_q == C_BW'(C_NBEATS - 1));
    assign w_accept    = out_valid_o & out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int l = 0; l < LANES; l++) begin
                        mem_q[b][r][l] <= '0;
                    end
                end
            end
        end else if (w_wr_ok) begin
            mem_q[wsel_q][wr_row_i][wr_lane_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state_q <= C_IDLE;
            beat_q  <= '0;
            full_q  <= '0;
            wsel_q  <= 1'b0;
            rsel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            full_q  <= full_d;
            wsel_q  <= wsel_d;
            rsel_q  <= rsel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        full_d  = full_q;
        wsel_d  = wsel_q;
        rsel_d  = rsel_q;
        case (state_q)
            C_IDLE: begin
                if (full_q[rsel_q]) begin
                    state_d = C_STREAM;
                    beat_d  = '0;
                end
            end
            C_STREAM: begin
                if (w_accept) begin
                    if (w_last) begin
                        state_d        = C_IDLE;
                        beat_d         = '0;
                        full_d[rsel_q] = 1'b0;
                        rsel_d         = ~rsel_q;
                    end else begin
                        beat_d = beat_q + C_BW'(1);
                    end
                end
            end
            default: state_d = C_IDLE;
        endcase
        if (w_commit_ok) begin
            full_d[wsel_q] = 1'b1;
            wsel_d         = ~wsel_q;
        end
    end

    always_comb begin
        out_valid_o = (state_q == C_STREAM);
        out_last_o  = out_valid_o && w_last;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef SKEW_EN
        // Lane l lags by l beats; outside its tile window it emits zero.
        logic [C_BW-1:0] w_row;
        logic            w_hit;
        assign w_row = beat_q - C_BW'(l);
        assign w_hit = (beat_q >= C_BW'(l)) && (w_row < C_BW'(ROWS));
        assign out_data_o[l*DATA_WIDTH +: DATA_WIDTH] =
            w_hit ? mem_q[rsel_q][w_row[C_RW-1:0]][l] : '0;
`else
        assign out_data_o[l*DATA_WIDTH +: DATA_WIDTH] = mem_q[rsel_q][beat_q[C_RW-1:0]][l];
`endif
    end

endmodule
`default_nettype wire

// File: doc/pingpong_tile_buffer.md
# pingpong_tile_buffer

Two-bank ping-pong tile buffer between the operand loader and a systolic array. A ROWS x LANES tile is written element by element into the fill bank and committed. The committed bank is then streamed out one row-vector per beat over a valid/ready handshake, optionally diagonally skewed for direct systolic injection. Writer and reader run concurrently: while one bank streams, the other bank fills.

## Interface
- DATA_WIDTH, 8, element width
- LANES, 4, elements per output vector (>=1)
- ROWS, 4, rows per tile (>=2)
- clk  in  1  clock
- rst  in  1  reset; **reset rst, synchronous, active-high; clock clk**
- flush  in  1  sync abort: drops all tiles and returns to reset state; data storage is not cleared
- wr_en  in  1  write element when wr_ready
- wr_row  in  $clog2(ROWS)  row address
- wr_lane  in  $clog2(LANES) (min 1)  lane address
- wr_data  in  DATA_WIDTH  element
- wr_commit  in  1  mark the fill bank full and hand it to the reader
- wr_ready  out  1  fill bank is writable (not full)
- out_valid  out  1  out_data holds a beat
- out_ready  in  1  consumer accepts the beat
- out_data  out  DATA_WIDTH*LANES  lane l at bits [l*DATA_WIDTH +: DATA_WIDTH]
- out_last  out  1  final beat of the tile

## Operation
- State registers:
  - bank0/bank1 storage
  - full[1:0]
  - wsel: fill bank
  - rsel: drain bank
  - FSM {IDLE, STREAM}
  - beat counter, width $clog2(NBEATS+1)
- Write side:
  - When wr_en && wr_ready: store bank[wsel][wr_row][wr_lane] <= wr_data.
  - When wr_commit && wr_ready: full[wsel] <= 1 and wsel toggles.
  - A write and a commit in the same cycle are both applied; that write belongs to the committed tile.
  - wr_en or wr_commit while !wr_ready is ignored.
  - Out-of-range wr_row or wr_lane is ignored.
  - wr_ready = !full[wsel].
- Read FSM:
  - IDLE -> STREAM when full[rsel]; beat resets to 0.
  - In STREAM, a beat is accepted when out_valid && out_ready; accepted beats increment beat.
  - When the accepted beat is NBEATS-1: full[rsel] <= 0, rsel toggles, FSM -> IDLE.
  - out_valid = (state == STREAM).
  - out_last = out_valid && beat == NBEATS-1.
  - out_data is held stable while out_valid && !out_ready.
- Unskewed mode: NBEATS = ROWS. Lane l = bank[rsel][beat][l].
- Release and commit in the same cycle are both applied. They always target different banks, because a writable bank is never full.
- flush, or rst, sets full = 0, wsel = rsel = 0, FSM = IDLE, beat = 0. rst additionally zeroes both banks. flush has priority over all write and read activity in its cycle.

## Timing
- Reset values:
  - wr_ready = 1
  - out_valid = 0
  - out_last = 0
  - out_data = 0
- Commit-to-first-beat latency: a commit in cycle N when the reader is IDLE on that bank gives out_valid in cycle N+2. In cycle N+1 full is visible; the FSM enters STREAM at the end of N+1.
- Minimum gap between tiles is 1 IDLE cycle.
- Full-throughput drain is NBEATS + 1 cycles per tile.
- Both banks full: wr_ready stays 0 until the cycle after the current tile's last beat is accepted.
- out_data is combinational from registered state (bank, rsel, beat); there is no extra pipeline stage.

## Configuration
- SKEW_EN defined:
  - NBEATS = ROWS + LANES - 1.
  - Lane l outputs bank[rsel][beat-l][l] when 0 <= beat-l < ROWS, otherwise 0.
  - This produces a diagonal wavefront: lane l is delayed l beats.
- SKEW_EN undefined:
  - NBEATS = ROWS; no skew.
  - Skew logic is absent from the netlist.

## Test plan
(All scenarios: DATA_WIDTH=8, LANES=4, ROWS=4.)
- **Basic tile, unskewed.** Write elements r*16+l and commit. Hold out_ready=1.
  - Required: 4 beats, e.g. beat 2 = {0x23,0x22,0x21,0x20}.
  - out_last on beat 3 only; out_valid first seen 2 cycles after commit.
- **Ping-pong overlap.** Commit tile A, then write and commit tile B while A streams.
  - Required: B follows A after 1 idle cycle.
  - wr_ready = 0 after B's commit until A's last beat is accepted.
- **Backpressure.** out_ready toggles 1,0,0,1 during streaming.
  - Required: out_data stable while stalled; no beat lost or duplicated; 4 accepted beats total.
- **Blocked writer.** Commit two tiles; with the reader held (out_ready=0), issue wr_en and wr_commit.
  - Required: both ignored.
  - After both tiles drain, tile contents are exactly the two originally written.
- **Flush mid-stream.** Assert flush after beat 1 of a tile.
  - Required: next cycle out_valid = 0, wr_ready = 1, wsel = rsel = 0.
  - A new tile then streams normally.
- **SKEW_EN build.** Using the basic-tile data with SKEW_EN defined:
  - Required: 7 beats.
  - Beat 0 = {0,0,0,0x00}; beat 3 = {0x03,0x12,0x21,0x30} as lane3..lane0; beat 6 = {0x33,0,0,0}.
  - out_last on beat 6.
